// File: rtl/sd4_mac_acc.sv
// Streaming N-lane SD4 multiply-accumulate: exact wide accumulation over a
// variable-length dot product, converted to FP16 (round toward zero).
module sd4_mac_acc #(
  parameter int N_LANES = 9,
  parameter int ACC_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [8*N_LANES-1:0]   image,
  input  logic [4*N_LANES-1:0]   weight,
  input  logic [4:0]             exp_bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out,
  output logic                   out_sat,
  output logic [15:0]            out_beats
);

  localparam int KW = $clog2(ACC_W);
  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = -ACC_MAX;

  logic en;

  // S1: input register
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_last_q, s1_last_d;
  logic [8*N_LANES-1:0] s1_image_q, s1_image_d;
  logic [4*N_LANES-1:0] s1_weight_q, s1_weight_d;
  logic [4:0]           s1_bias_q, s1_bias_d;

  // S2: lane sum
  logic             s2_valid_q, s2_valid_d;
  logic             s2_last_q, s2_last_d;
  logic [4:0]       s2_bias_q, s2_bias_d;
  logic [ACC_W-1:0] s2_sum_q, s2_sum_d;

  // S3: running accumulator and end-of-dot-product snapshot
  logic             acc_sat_q, acc_sat_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             s3_valid_q, s3_valid_d;
  logic [ACC_W-1:0] s3_acc_q, s3_acc_d;
  logic             s3_sat_q, s3_sat_d;
  logic [15:0]      s3_beats_q, s3_beats_d;
  logic [4:0]       s3_bias_q, s3_bias_d;

  // Conversion front half: magnitude and leading-one position
  logic             cv_valid_q, cv_valid_d;
  logic             cv_sign_q, cv_sign_d;
  logic             cv_zero_q, cv_zero_d;
  logic             cv_sat_q, cv_sat_d;
  logic [ACC_W-1:0] cv_mag_q, cv_mag_d;
  logic [KW-1:0]    cv_k_q, cv_k_d;
  logic [15:0]      cv_beats_q, cv_beats_d;
  logic [4:0]       cv_bias_q, cv_bias_d;

  // Output register
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_q, out_d;
  logic        out_sat_q, out_sat_d;
  logic [15:0] out_beats_q, out_beats_d;

  assign en        = !(out_valid_q && !out_ready);
  assign in_ready  = en && !rst;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_sat   = out_sat_q;
  assign out_beats = out_beats_q;

  // Per-lane product (-1)^sign * sig * w * 2^sh, exact in 22 signed bits
  logic [N_LANES-1:0][21:0] lane_p;

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    logic              sgn;
    logic [3:0]        e;
    logic [2:0]        m;
    logic [3:0]        w;
    logic [3:0]        sig;
    logic [3:0]        sh;
    logic signed [8:0] sw;
    logic [21:0]       prod;
    assign sgn  = s1_image_q[8*gi+7];
    assign e    = s1_image_q[8*gi+3 +: 4];
    assign m    = s1_image_q[8*gi +: 3];
    assign w    = s1_weight_q[4*gi +: 4];
    assign sig  = {(e != 4'd0), m};
    assign sh   = (e != 4'd0) ? e - 4'd1 : 4'd0;
    assign sw   = $signed({5'b0, sig}) * $signed({{5{w[3]}}, w});
    assign prod = {{13{sw[8]}}, sw} << sh;
    assign lane_p[gi] = sgn ? -prod : prod;
  end

  logic [ACC_W-1:0] lane_sum;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lane_sum = lane_sum + ACC_W'($signed(lane_p[i]));
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_image_d  = s1_image_q;
    s1_weight_d = s1_weight_q;
    s1_bias_d   = s1_bias_q;
    s2_valid_d  = s2_valid_q;
    s2_last_d   = s2_last_q;
    s2_bias_d   = s2_bias_q;
    s2_sum_d    = s2_sum_q;
    if (en) begin
      s1_valid_d  = in_valid;
      s1_last_d   = in_last;
      s1_image_d  = image;
      s1_weight_d = weight;
      s1_bias_d   = exp_bias;
      s2_valid_d  = s1_valid_q;
      s2_last_d   = s1_last_q;
      s2_bias_d   = s1_bias_q;
      s2_sum_d    = lane_sum;
    end
  end

  logic signed [ACC_W:0] sum_wide;
  logic [ACC_W-1:0]      acc_new;
  logic                  ovf;
  logic [15:0]           cnt_new;

  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {s2_sum_q[ACC_W-1], s2_sum_q};
    ovf      = 1'b0;
    acc_new  = sum_wide[ACC_W-1:0];
    if (sum_wide > ACC_MAX) begin
      acc_new = ACC_MAX[ACC_W-1:0];
      ovf     = 1'b1;
    end else if (sum_wide < ACC_MIN) begin
      acc_new = ACC_MIN[ACC_W-1:0];
      ovf     = 1'b1;
    end
    cnt_new = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  end

  always_comb begin
    acc_d      = acc_q;
    acc_sat_d  = acc_sat_q;
    cnt_d      = cnt_q;
    s3_valid_d = s3_valid_q;
    s3_acc_d   = s3_acc_q;
    s3_sat_d   = s3_sat_q;
    s3_beats_d = s3_beats_q;
    s3_bias_d  = s3_bias_q;
    if (en) begin
      s3_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          // Hand the finished dot product on and start the next one from zero
          s3_valid_d = 1'b1;
          s3_acc_d   = acc_new;
          s3_sat_d   = acc_sat_q | ovf;
          s3_beats_d = cnt_new;
          s3_bias_d  = s2_bias_q;
          acc_d      = '0;
          acc_sat_d  = 1'b0;
          cnt_d      = '0;
        end else begin
          acc_d     = acc_new;
          acc_sat_d = acc_sat_q | ovf;
          cnt_d     = cnt_new;
        end
      end
    end
  end

  logic [ACC_W-1:0] abs_acc;
  logic [KW-1:0]    lead_k;

  always_comb begin
    abs_acc = s3_acc_q[ACC_W-1] ? -s3_acc_q : s3_acc_q;
    lead_k  = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (abs_acc[i]) lead_k = KW'(i);
    end
  end

  always_comb begin
    cv_valid_d = cv_valid_q;
    cv_sign_d  = cv_sign_q;
    cv_zero_d  = cv_zero_q;
    cv_sat_d   = cv_sat_q;
    cv_mag_d   = cv_mag_q;
    cv_k_d     = cv_k_q;
    cv_beats_d = cv_beats_q;
    cv_bias_d  = cv_bias_q;
    if (en) begin
      cv_valid_d = s3_valid_q;
      cv_sign_d  = s3_acc_q[ACC_W-1];
      cv_zero_d  = (s3_acc_q == '0);
      cv_sat_d   = s3_sat_q;
      cv_mag_d   = abs_acc;
      cv_k_d     = lead_k;
      cv_beats_d = s3_beats_q;
      cv_bias_d  = s3_bias_q;
    end
  end

  int          exp_i;
  logic [9:0]  norm_mant;
  logic [9:0]  sub_mant;
  logic [15:0] fp16;

  always_comb begin
    exp_i     = int'(cv_k_q) - int'(cv_bias_q) + 15;
    // Normal: the ten bits just below the leading one, zero-filled past bit 0
    norm_mant = 10'({cv_mag_q, 10'b0} >> cv_k_q);
    if (cv_bias_q <= 5'd24) begin
      sub_mant = 10'({10'b0, cv_mag_q} << (5'd24 - cv_bias_q));
    end else begin
      sub_mant = 10'({10'b0, cv_mag_q} >> (cv_bias_q - 5'd24));
    end
    if (cv_sat_q) begin
      fp16 = {cv_sign_q, 5'h1F, 10'h000};
    end else if (cv_zero_q) begin
      fp16 = 16'h0000;
    end else if (exp_i >= 31) begin
      fp16 = {cv_sign_q, 5'h1F, 10'h000};
    end else if (exp_i >= 1) begin
      fp16 = {cv_sign_q, 5'(exp_i), norm_mant};
    end else begin
      fp16 = {cv_sign_q, 5'h00, sub_mant};
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_sat_d   = out_sat_q;
    out_beats_d = out_beats_q;
    if (en) begin
      out_valid_d = cv_valid_q;
      if (cv_valid_q) begin
        out_d       = fp16;
        out_sat_d   = cv_sat_q;
        out_beats_d = cv_beats_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      cv_valid_q  <= 1'b0;
      acc_q       <= '0;
      acc_sat_q   <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_sat_q   <= 1'b0;
      out_beats_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      cv_valid_q  <= cv_valid_d;
      acc_q       <= acc_d;
      acc_sat_q   <= acc_sat_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_sat_q   <= out_sat_d;
      out_beats_q <= out_beats_d;
    end
  end

  // Payload registers are qualified by the valids above and need no reset
  always_ff @(posedge clk) begin
    s1_last_q   <= s1_last_d;
    s1_image_q  <= s1_image_d;
    s1_weight_q <= s1_weight_d;
    s1_bias_q   <= s1_bias_d;
    s2_last_q   <= s2_last_d;
    s2_bias_q   <= s2_bias_d;
    s2_sum_q    <= s2_sum_d;
    s3_acc_q    <= s3_acc_d;
    s3_sat_q    <= s3_sat_d;
    s3_beats_q  <= s3_beats_d;
    s3_bias_q   <= s3_bias_d;
    cv_sign_q   <= cv_sign_d;
    cv_zero_q   <= cv_zero_d;
    cv_sat_q    <= cv_sat_d;
    cv_mag_q    <= cv_mag_d;
    cv_k_q      <= cv_k_d;
    cv_beats_q  <= cv_beats_d;
    cv_bias_q   <= cv_bias_d;
  end

endmodule

// File: tb/tb_sd4_mac_acc.sv
// Scoreboard bench for sd4_mac_acc: stimulus pushes expected FP16 results from
// an arithmetic reference model; an independent monitor pops and compares.
module tb_sd4_mac_acc;

  localparam int NL = 9;
  localparam int AW = 26;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [8*NL-1:0]  image;
  logic [4*NL-1:0]  weight;
  logic [4:0]       exp_bias;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out;
  logic             out_sat;
  logic [15:0]      out_beats;

  sd4_mac_acc #(.N_LANES(NL), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .image(image), .weight(weight), .exp_bias(exp_bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_sat(out_sat), .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] out;
    logic        sat;
    logic [15:0] beats;
    int          edge_no;
    bit          chk_lat;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
  bit   chk_lat = 1'b0;
  int   dp_seen = 0;

  longint m_acc = 0;
  bit     m_sat = 1'b0;
  int     m_cnt = 0;
  localparam longint AMAX = (longint'(1) << (AW - 1)) - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint lane_value(input logic [7:0] img, input logic [3:0] wt);
    int e, m, s, sh, w;
    longint p;
    e  = int'(img[6:3]);
    m  = int'(img[2:0]);
    s  = (e != 0) ? 8 + m : m;
    sh = (e != 0) ? e - 1 : 0;
    w  = wt[3] ? int'(wt) - 16 : int'(wt);
    p  = longint'(s * w) * (longint'(1) << sh);
    return img[7] ? -p : p;
  endfunction

  function automatic logic [15:0] fp16_model(input longint a, input int sb, input bit sat);
    longint mag;
    int k, e;
    logic sgn;
    logic [15:0] mant;
    sgn = (a < 0);
    if (sat) return sgn ? 16'hFC00 : 16'h7C00;
    if (a == 0) return 16'h0000;
    mag = sgn ? -a : a;
    k = 0;
    while ((mag >> (k + 1)) != 0) k++;
    e = k - sb + 15;
    if (e >= 31) return sgn ? 16'hFC00 : 16'h7C00;
    if (e >= 1) begin
      mant = 16'(((mag << 10) >> k) & 1023);
      return {sgn, 5'(e), mant[9:0]};
    end
    mant = (sb <= 24) ? 16'(mag << (24 - sb)) : 16'(mag >> (sb - 24));
    return {sgn, 5'b0, mant[9:0]};
  endfunction

  task automatic model_beat(input logic [8*NL-1:0] img, input logic [4*NL-1:0] wt,
                            input logic last, input logic [4:0] bias, input int edge_no);
    longint beat_sum = 0;
    exp_t   e;
    for (int i = 0; i < NL; i++) beat_sum += lane_value(img[8*i +: 8], wt[4*i +: 4]);
    m_acc += beat_sum;
    if (m_acc > AMAX) begin m_acc = AMAX; m_sat = 1'b1; end
    if (m_acc < -AMAX) begin m_acc = -AMAX; m_sat = 1'b1; end
    if (m_cnt < 65535) m_cnt++;
    if (last) begin
      e.out = fp16_model(m_acc, int'(bias), m_sat);
      e.sat = m_sat;
      e.beats = 16'(m_cnt);
      e.edge_no = edge_no;
      e.chk_lat = chk_lat;
      sb_q.push_back(e);
      m_acc = 0; m_sat = 1'b0; m_cnt = 0;
    end
  endtask

  task automatic send_beat(input logic [8*NL-1:0] img, input logic [4*NL-1:0] wt,
                           input logic last, input logic [4:0] bias);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1; image = img; weight = wt; in_last = last; exp_bias = bias;
    #2;
    while (!in_ready && waited < 300) begin
      @(negedge clk); #2; waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      model_beat(img, wt, last, bias, cyc + 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_dp(input logic [8*NL-1:0] img, input logic [4*NL-1:0] wt,
                         input int nbeats, input logic [4:0] bias);
    for (int b = 0; b < nbeats; b++) send_beat(img, wt, b == nbeats - 1, bias);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Ready generator
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops on every handshake, checks hold behaviour while stalled
  initial begin
    bit          stall_prev = 1'b0;
    logic [15:0] h_out, h_beats;
    logic        h_sat;
    exp_t        e;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_out", 32'(out), 32'(h_out));
          check("hold_sat", 32'(out_sat), 32'(h_sat));
          check("hold_beats", 32'(out_beats), 32'(h_beats));
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_output", 32'(out_valid), 32'd0);
          end else begin
            e = sb_q.pop_front();
            dp_seen++;
            $display("[TB] dp %0d out=%h sat=%b beats=%0d | model out=%h sat=%b beats=%0d",
                     dp_seen, out, out_sat, out_beats, e.out, e.sat, e.beats);
            check("out", 32'(out), 32'(e.out));
            check("out_sat", 32'(out_sat), 32'(e.sat));
            check("out_beats", 32'(out_beats), 32'(e.beats));
            if (e.chk_lat) check("latency", 32'(cyc), 32'(e.edge_no + 4));
          end
        end
        if (out_valid && !out_ready) begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
          stall_prev = 1'b1;
          h_out = out; h_sat = out_sat; h_beats = out_beats;
        end else begin
          stall_prev = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8*NL-1:0] t_img, sat_img, r_img;
    logic [4*NL-1:0] t_wp, t_wn, sat_wt, r_wt;
    logic [7:0]      b8;
    int              nb;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    image = '0; weight = '0; exp_bias = '0;
    t_img = '0; t_img[7:0] = 8'h38;
    t_wp = '0;  t_wp[3:0] = 4'h1;
    t_wn = '0;  t_wn[3:0] = 4'hF;
    sat_img = {NL{8'h7F}};
    sat_wt  = {NL{4'h7}};

    repeat (3) @(negedge clk);
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_out_beats", 32'(out_beats), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed cases from the datasheet, latency checked with no back-pressure
    chk_lat = 1'b1;
    send_dp(t_img, t_wp, 1, 5'd9);  drain();
    send_dp(t_img, t_wn, 1, 5'd9);  drain();
    send_dp(t_img, t_wp, 3, 5'd9);  drain();
    send_dp(t_img, t_wp, 1, 5'd0);  drain();
    r_img = '0; r_img[7:0] = 8'h01;
    send_dp(r_img, t_wp, 1, 5'd24); drain();
    // Back-to-back one-beat dot products
    send_dp(t_img, t_wp, 1, 5'd9);
    send_dp(t_img, t_wn, 1, 5'd10);
    send_dp(r_img, t_wn, 1, 5'd30);
    drain();
    chk_lat = 1'b0;

    // Saturation under held back-pressure, then release
    ready_mode = 2;
    send_dp(sat_img, sat_wt, 3, 5'd0);
    send_dp(t_img, t_wp, 1, 5'd9);
    repeat (12) @(negedge clk);
    #2;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    ready_mode = 1;
    drain();

    // Reset in the middle of a dot product
    send_beat(t_img, t_wp, 1'b0, 5'd9);
    send_beat(t_img, t_wp, 1'b0, 5'd9);
    @(negedge clk); rst = 1'b1;
    #2;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    m_acc = 0; m_sat = 1'b0; m_cnt = 0;
    #2;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    chk_lat = 1'b1;
    send_dp(t_img, t_wp, 1, 5'd9);
    drain();
    chk_lat = 1'b0;

    // Randomised traffic with random back-pressure and bubbles
    ready_mode = 0;
    for (int d = 0; d < 400; d++) begin
      nb = $urandom_range(1, 4);
      exp_bias = 5'($urandom_range(0, 31));
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < NL; i++) begin
          if ($urandom_range(0, 3) == 0) b8 = 8'($urandom);
          else b8 = {1'($urandom), 4'($urandom_range(0, 6)), 3'($urandom)};
          r_img[8*i +: 8] = b8;
          r_wt[4*i +: 4]  = 4'($urandom);
        end
        if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
        send_beat(r_img, r_wt, b == nb - 1, exp_bias);
      end
    end
    ready_mode = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sd4_mac_acc.md
# sd4_mac_acc

Parametrised streaming successor to the SD4 9-lane MAC. Accepts one beat per cycle of N_LANES (8-bit image, 4-bit signed weight) pairs over a valid/ready handshake. Accumulates exactly in a wide fixed-point accumulator across a variable number of beats terminated by `in_last`. Emits one FP16 result per dot product with saturation flag and beat count; sits between the operand buffers and the FP16 output writeback.

## Interface
- N_LANES, 9, lanes per beat (1..16)
- ACC_W, 32, accumulator width in bits; must satisfy ACC_W ≥ 22+clog2(N_LANES)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  final beat of current dot product
- image  in  8*N_LANES  lane i = image[8i+7:8i] = {sign, e[3:0], m[2:0]}
- weight  in  4*N_LANES  lane i = weight[4i+3:4i], two's complement −8..7
- exp_bias  in  5  scale S (unsigned 0..31), sampled with the last beat only
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out  out  16  FP16 result
- out_sat  out  1  accumulator saturated during this dot product
- out_beats  out  16  beats in this dot product, saturating at 65535

## Operation
- Lane product:
  - s = e≠0 ? {1,m} : {0,m}; sh = e≠0 ? e−1 : 0.
  - p = (−1)^sign × s × w × 2^sh; signed 22 bits (|p| ≤ 120×2^14).
- Lane sum: exact signed sum of all lanes, sign-extended to ACC_W.
- Accumulator A:
  - A += lane sum each accepted beat.
  - Saturates at ±(2^(ACC_W−1)−1) and sets a sticky sat flag.
  - After the last beat's sum is taken: A, the sat flag and the beat counter snapshot into the conversion stage, then clear to 0. The next beat starts a fresh dot product.
- Conversion of real value A×2^−S to FP16, round toward zero:
  - A=0 → 0x0000.
  - Otherwise k = msb index of |A|; biased exponent E = k−S+15.
  - E ≥ 31 → ±inf (0x7C00 / 0xFC00).
  - 1 ≤ E ≤ 30 → normal; mantissa = |A| bits k−1..k−10, zero-filled below bit 0.
  - E ≤ 0 → subnormal; mantissa = floor(|A|×2^(24−S)), exponent field 0; result may be ±0.
  - sat flag set → out = ±inf by sign of A; out_sat=1.
- Pipeline:
  - S1: input register.
  - S2: products and lane sum.
  - S3: accumulate / snapshot.
  - S4: conversion into the output register.
- Global enable en = !(out_valid && !out_ready). All stages, including bubbles, advance only when en. in_ready = en && !rst.
- Output register holds out, out_sat and out_beats stable while out_valid && !out_ready.

## Timing
- Reset, synchronous: all stage valids 0; A=0; sat=0; beat counter 0; out_valid=0, out=0, out_sat=0, out_beats=0; in_ready=0 during the rst cycle.
- rst mid-dot-product discards partial accumulation and any in-flight results.
- Latency: last beat accepted at edge t → out_valid high after edge t+4 when there is no stall. Each stall cycle adds one.
- Throughput is one beat per cycle. Back-to-back dot products are allowed: a new first beat can arrive the cycle after a last beat, and one-beat dot products can come every cycle.
- out_valid && out_ready at the same edge that S4 holds a new result: the register reloads and out_valid stays 1.
- in_valid=0 cycles are bubbles; they do not touch A or the counter.
- Beat counter counts accepted beats including the last; 65535 holds.

## Test plan
- One beat, lane0 image=0x38, weight=1, other lanes 0, in_last=1, S=9 → out=0x3C00, out_sat=0, out_beats=1, out_valid at t+4.
- Same stimulus with weight=0xF (−1) → out=0xBC00.
- Three beats as in the first test (last on beat 3), S=9 → A=1536 → out=0x4200, out_beats=3.
- Same as the first test with S=0 → 0x6000. Lane0 image=0x01, weight=1, S=24 → A=1 → subnormal 0x0001.
- Saturation and back-pressure:
  - ACC_W=26, three beats of all lanes image=0x7F, weight=7 → out_sat=1, out=0x7C00.
  - Hold out_ready=0 → in_ready=0 from the next cycle; out stays stable.
  - Release out_ready → the queued next result follows with no loss.
- Reset mid-operation: assert rst after two of three beats, then send the first-test stimulus → out=0x3C00, out_beats=1, with no residue from the aborted dot product.
